// File: rtl/led_mode_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : led_mode_sequencer
// Purpose  : Front-panel LED1 controller. Two active-low push-buttons are
//            synchronised and debounced, and each accepted press becomes a
//            one-cycle event. BUT1 events step the display mode forward and
//            BUT2 events force it to OFF. LED1 is driven steady or blinking
//            from one shared half-period counter.
// Ports    : CLK   - system clock, rising edge
//            RST_N - asynchronous active-low reset, released synchronously
//            BUT1  - raw button, active-low; a press advances the mode
//            BUT2  - raw button, active-low; a press forces mode OFF
//            LED1  - registered LED drive, 1 = lit
//            MODE  - registered mode: 0 OFF, 1 ON, 2 BLINK_SLOW,
//                    3 BLINK_FAST, 4 DIM (DIM only with LED_DIM_MODE_EN)
// Options  : LED_DIM_MODE_EN - adds the DIM mode (1/8 duty PWM) after
//            BLINK_FAST in the BUT1 sequence.
// Revision : 1.0 - initial release
// ============================================================================
module led_mode_sequencer #(
  parameter int DEBOUNCE_CYCLES  = 250000,
  parameter int SLOW_HALF_PERIOD = 12500000,
  parameter int FAST_HALF_PERIOD = 3125000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       BUT1,
  input  logic       BUT2,
  output logic       LED1,
  output logic [2:0] MODE
);

  localparam int c_DB_W    = $clog2(DEBOUNCE_CYCLES);
  localparam int c_HMAX    = (SLOW_HALF_PERIOD > FAST_HALF_PERIOD) ?
                             SLOW_HALF_PERIOD : FAST_HALF_PERIOD;
  localparam int c_BLINK_W = (c_HMAX > 1) ? $clog2(c_HMAX) : 1;

  localparam logic [c_DB_W-1:0]    c_DB_LAST   = c_DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_BLINK_W-1:0] c_SLOW_LAST = c_BLINK_W'(SLOW_HALF_PERIOD - 1);
  localparam logic [c_BLINK_W-1:0] c_FAST_LAST = c_BLINK_W'(FAST_HALF_PERIOD - 1);

`ifdef LED_DIM_MODE_EN
  typedef enum logic [2:0] {
    S_OFF  = 3'd0,
    S_ON   = 3'd1,
    S_SLOW = 3'd2,
    S_FAST = 3'd3,
    S_DIM  = 3'd4
  } mode_t;
`else
  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_ON   = 2'd1,
    S_SLOW = 2'd2,
    S_FAST = 2'd3
  } mode_t;
`endif

  logic [1:0] w_raw;
  logic [1:0] w_press;   // bit 0 = BUT1 event, bit 1 = BUT2 event

  assign w_raw = {BUT2, BUT1};

  // --------------------------------------------------------------------------
  // Per-button synchroniser, debouncer and press-event generator
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    logic              r_s1;
    logic              r_s2;
    logic              r_stable;
    logic              r_press;
    logic [c_DB_W-1:0] r_cnt;

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        r_s1     <= 1'b1;
        r_s2     <= 1'b1;
        r_stable <= 1'b1;
        r_press  <= 1'b0;
        r_cnt    <= '0;
      end else begin
        r_s1    <= w_raw[gi];
        r_s2    <= r_s1;
        r_press <= 1'b0;
        if (r_s2 == r_stable) begin
          r_cnt <= '0;
        end else if (r_cnt == c_DB_LAST) begin
          // New level held long enough: accept it. Only the 1->0 edge
          // (a press) raises an event.
          r_stable <= r_s2;
          r_cnt    <= '0;
          r_press  <= ~r_s2;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end

    assign w_press[gi] = r_press;
  end

  // --------------------------------------------------------------------------
  // Mode sequencing and LED drive
  // --------------------------------------------------------------------------
  mode_t                r_mode;
  mode_t                w_next_mode;
  logic                 w_change;
  logic                 r_led;
  logic                 r_phase;
  logic [c_BLINK_W-1:0] r_blink_cnt;
  logic [c_BLINK_W-1:0] w_half_last;
`ifdef LED_DIM_MODE_EN
  logic [2:0]           r_pwm;
`endif

  always_comb begin
    w_next_mode = r_mode;
    if (w_press[1]) begin
      // BUT2 has priority over a simultaneous BUT1 event
      w_next_mode = S_OFF;
    end else if (w_press[0]) begin
      case (r_mode)
        S_OFF:   w_next_mode = S_ON;
        S_ON:    w_next_mode = S_SLOW;
        S_SLOW:  w_next_mode = S_FAST;
`ifdef LED_DIM_MODE_EN
        S_FAST:  w_next_mode = S_DIM;
`endif
        default: w_next_mode = S_OFF;
      endcase
    end
    // BUT2 while already OFF lands here as "no change"
    w_change = (w_next_mode != r_mode);
  end

  assign w_half_last = (r_mode == S_SLOW) ? c_SLOW_LAST : c_FAST_LAST;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_mode      <= S_OFF;
      r_led       <= 1'b0;
      r_phase     <= 1'b1;
      r_blink_cnt <= '0;
`ifdef LED_DIM_MODE_EN
      r_pwm       <= '0;
`endif
    end else begin
      r_mode <= w_next_mode;
`ifdef LED_DIM_MODE_EN
      r_pwm  <= r_pwm + 3'd1;
`endif
      if (w_change) begin
        // Every non-OFF mode starts lit: ON is steady, blink modes begin in
        // phase 1, and DIM begins at PWM count 0.
        r_blink_cnt <= '0;
        r_phase     <= 1'b1;
        r_led       <= (w_next_mode != S_OFF);
`ifdef LED_DIM_MODE_EN
        if (w_next_mode == S_DIM) begin
          r_pwm <= '0;
        end
`endif
      end else begin
        case (r_mode)
          S_SLOW, S_FAST: begin
            if (r_blink_cnt == w_half_last) begin
              r_blink_cnt <= '0;
              r_phase     <= ~r_phase;
              r_led       <= ~r_phase;
            end else begin
              r_blink_cnt <= r_blink_cnt + 1'b1;
              r_led       <= r_phase;
            end
          end
          S_ON: begin
            r_blink_cnt <= '0;
            r_led       <= 1'b1;
          end
`ifdef LED_DIM_MODE_EN
          S_DIM: begin
            // Lit when the PWM counter wraps to 0 on this edge
            r_blink_cnt <= '0;
            r_led       <= (r_pwm == 3'd7);
          end
`endif
          default: begin
            r_blink_cnt <= '0;
            r_led       <= 1'b0;
          end
        endcase
      end
    end
  end

  assign LED1 = r_led;
`ifdef LED_DIM_MODE_EN
  assign MODE = r_mode;
`else
  assign MODE = {1'b0, r_mode};
`endif

endmodule
`default_nettype wire

// File: tb/tb_led_mode_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_mode_sequencer
// Purpose  : Self-checking bench for led_mode_sequencer. A behavioural model
//            predicts MODE/LED1 for every clock; predictions are queued and
//            a monitor compares them against the DUT on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_mode_sequencer;

  localparam int DB = 4;
  localparam int SH = 8;
  localparam int FH = 2;

  logic       CLK   = 1'b0;
  logic       RST_N = 1'b0;
  logic       BUT1  = 1'b1;
  logic       BUT2  = 1'b1;
  logic       LED1;
  logic [2:0] MODE;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  led_mode_sequencer #(
    .DEBOUNCE_CYCLES  (DB),
    .SLOW_HALF_PERIOD (SH),
    .FAST_HALF_PERIOD (FH)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .BUT1  (BUT1),
    .BUT2  (BUT2),
    .LED1  (LED1),
    .MODE  (MODE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int mode;
    bit led;
  } exp_t;

  exp_t sbq[$];

  // Reference model state
  bit stab[2];
  int run[2];
  bit pipe1[$];
  bit pipe2[$];
  int m_mode;
  int m_t;      // edges since the current mode was entered

  function automatic int next_mode(input int m);
`ifdef LED_DIM_MODE_EN
    return (m == 4) ? 0 : m + 1;
`else
    return (m == 3) ? 0 : m + 1;
`endif
  endfunction

  function automatic bit exp_led(input int m, input int t);
    case (m)
      1:       return 1'b1;
      2:       return ((t / SH) % 2) == 0;
      3:       return ((t / FH) % 2) == 0;
      4:       return (t % 8) == 0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      stab[i] = 1'b1;
      run[i]  = 0;
    end
    pipe1  = '{1'b0, 1'b0, 1'b0};
    pipe2  = '{1'b0, 1'b0, 1'b0};
    m_mode = 0;
    m_t    = 0;
  endtask

  // Model: a button level is accepted after DB consecutive raw samples that
  // differ from the current accepted level; a press accepted from the raw
  // sample taken at edge k changes MODE at edge k+3.
  always @(posedge CLK) begin
    bit raw[2];
    bit pr[2];
    bit p1, p2;
    int nm;
    cyc++;
    if (!RST_N) begin
      model_reset();
    end else begin
      raw[0] = BUT1;
      raw[1] = BUT2;
      for (int i = 0; i < 2; i++) begin
        pr[i] = 1'b0;
        if (raw[i] != stab[i]) run[i]++;
        else run[i] = 0;
        if (run[i] == DB) begin
          stab[i] = raw[i];
          run[i]  = 0;
          pr[i]   = !raw[i];
        end
      end
      pipe1.push_back(pr[0]);
      pipe2.push_back(pr[1]);
      p1 = pipe1.pop_front();
      p2 = pipe2.pop_front();
      nm = m_mode;
      if (p2) nm = 0;
      else if (p1) nm = next_mode(m_mode);
      if (nm != m_mode) begin
        m_mode = nm;
        m_t    = 0;
      end else begin
        m_t++;
      end
      sbq.push_back('{m_mode, exp_led(m_mode, m_t)});
    end
  end

  // Monitor
  always @(negedge CLK) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      checks++;
      if (MODE !== 3'(e.mode) || LED1 !== e.led) begin
        errors++;
        $display("FAIL sb_out cycle %0d: got MODE=%0d LED1=%b, expected MODE=%0d LED1=%b",
                 cyc, MODE, LED1, e.mode, e.led);
      end
    end
  end

  task automatic drive(input bit b1, input bit b2, input int low, input int idle);
    @(negedge CLK);
    BUT1 = ~b1;
    BUT2 = ~b2;
    repeat (low) @(negedge CLK);
    BUT1 = 1'b1;
    BUT2 = 1'b1;
    repeat (idle) @(negedge CLK);
  endtask

  task automatic goto_mode(input int m);
    for (int i = 0; i < 8 && m_mode != m; i++) drive(1'b1, 1'b0, 6, 4);
    checks++;
    if (m_mode != m) begin
      errors++;
      $display("FAIL goto_mode: model reached %0d, wanted %0d", m_mode, m);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (LED1 !== 1'b0 || MODE !== 3'd0) begin
      errors++;
      $display("FAIL %s: got MODE=%0d LED1=%b, expected MODE=0 LED1=0", name, MODE, LED1);
    end
  endtask

  initial begin
    model_reset();
    // Reset held 3 cycles with buttons idle
    RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    check_reset_outputs("reset_hold");
    RST_N = 1'b1;

    drive(1'b1, 1'b0, 12, 20);   // clean long press: OFF -> ON
    drive(1'b1, 1'b0, 3, 12);    // too-short glitch: ignored
    drive(1'b1, 1'b0, 6, 40);    // ON -> BLINK_SLOW, observe blink
    drive(1'b1, 1'b0, 6, 20);    // -> BLINK_FAST
    drive(1'b1, 1'b0, 6, 30);    // -> OFF (or DIM)

    goto_mode(2);
    drive(1'b1, 1'b1, 6, 20);    // simultaneous presses: BUT2 wins

    goto_mode(3);
    drive(1'b1, 1'b0, 100, 20);  // held button: single advance only

    drive(1'b0, 1'b1, 6, 10);    // BUT2 in OFF or DIM
    drive(1'b0, 1'b1, 6, 10);    // BUT2 again while OFF

    // Asynchronous reset in BLINK_SLOW with a press partly debounced
    goto_mode(2);
    repeat (5) @(negedge CLK);
    BUT1 = 1'b0;
    repeat (2) @(negedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    @(negedge CLK);
    BUT1 = 1'b1;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    repeat (10) @(negedge CLK);

    // Randomised presses, glitches and simultaneous events
    for (int i = 0; i < 80; i++) begin
      int sel;
      sel = $urandom_range(0, 9);
      drive(sel != 9, sel >= 8, $urandom_range(1, 10), $urandom_range(0, 25));
    end

    repeat (20) @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety bound on total run time
  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time bound");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

endmodule
`default_nettype wire
